// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate self-test sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] DEF_EXPECT_MASK = 8'h20;
  localparam int         NUM_VEC         = 8;
  localparam int         CNT_W           = 4;

endpackage

// File: rtl/gate_seq_if.sv
// Controller <-> gate/host signal bundle; the loop input exists only when GATE_SEQ_LOOP_EN is defined.
interface gate_seq_if;
  import gate_seq_pkg::*;

  logic             start;
  logic             dut_out;
  logic [2:0]       stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [7:0]       fail_map;
`ifdef GATE_SEQ_LOOP_EN
  logic             loop;

  modport master (input start, dut_out, loop,
                  output stim, busy, done, pass, err_count, fail_map);
  modport slave  (output start, dut_out, loop,
                  input stim, busy, done, pass, err_count, fail_map);
`else
  modport master (input start, dut_out,
                  output stim, busy, done, pass, err_count, fail_map);
  modport slave  (output start, dut_out,
                  input stim, busy, done, pass, err_count, fail_map);
`endif

endinterface

// File: rtl/gate_seq_settle_timer.sv
// Loadable down-counter that parks at zero; expired is high whenever the count is zero.
module gate_seq_settle_timer
  import gate_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_seq_controller.sv
// Walks a 3-input gate through all 8 input vectors, samples after a settle delay and scores against EXPECT_MASK.
// Optional GATE_SEQ_LOOP_EN: auto-restart while loop=1 with sticky results and err_count saturating at 15.
module gate_seq_controller
  import gate_seq_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECT_MASK   = DEF_EXPECT_MASK
) (
  input  logic       clk,
  input  logic       reset,
  gate_seq_if.master bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $fatal(1, "SETTLE_CYCLES must be in 1..15");
  end

`ifdef GATE_SEQ_LOOP_EN
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
`else
  localparam logic [CNT_W-1:0] ERR_MAX = CNT_W'(NUM_VEC);
`endif

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic [CNT_W-1:0] err_q;
  logic [7:0]       map_q;
  logic             done_q;
  logic             expired;
  logic             load;
  logic             start_ok;
  logic             last_vec;
  logic             mismatch;
  logic             loop_on;

`ifdef GATE_SEQ_LOOP_EN
  assign loop_on = bus.loop;
`else
  assign loop_on = 1'b0;
`endif

  assign start_ok = bus.start && (state == IDLE || state == DONE);
  assign last_vec = (idx == 3'(NUM_VEC - 1));
  assign mismatch = (bus.dut_out != EXPECT_MASK[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (expired)   state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (last_vec && !loop_on) ? DONE : SETTLE;
      DONE:    if (bus.start) state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reload on every entry into SETTLE, including the auto-restart path from SAMPLE.
  assign load = (state_nxt == SETTLE) && (state != SETTLE);

  gate_seq_settle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      err_q  <= '0;
      map_q  <= '0;
      done_q <= 1'b0;
    end else if (start_ok) begin
      idx    <= '0;
      err_q  <= '0;
      map_q  <= '0;
      done_q <= 1'b0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        map_q[idx] <= 1'b1;
        err_q      <= (err_q == ERR_MAX) ? err_q : err_q + CNT_W'(1);
      end
      if (last_vec) begin
        done_q <= 1'b1;
        idx    <= '0;
      end else begin
        idx <= idx + 3'd1;
      end
    end else if (state == SETTLE) begin
      // Ends the one-cycle done pulse of a looped restart.
      done_q <= 1'b0;
    end
  end

  assign bus.busy      = (state == SETTLE) || (state == SAMPLE);
  assign bus.stim      = bus.busy ? idx : 3'd0;
  assign bus.done      = done_q;
  assign bus.pass      = done_q && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.fail_map  = map_q;

endmodule

// File: tb/tb_gate_seq_controller.sv
// Randomized self-checking bench for gate_seq_controller against a truth-table reference model.
module tb_gate_seq_controller;

  localparam int S_A = 2;
  localparam int S_B = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] tbl = 8'h20;
  bit         delay_mode = 1'b0;
  bit         chatter = 1'b0;
  logic [1:0] dly_a = 2'b00;
  logic [1:0] dly_b = 2'b00;

  gate_seq_if bus_a ();
  gate_seq_if bus_b ();

  gate_seq_controller #(.SETTLE_CYCLES(S_A)) dut (.clk(clk), .reset(reset), .bus(bus_a));
  gate_seq_controller #(.SETTLE_CYCLES(S_B)) dut_fast (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  function automatic logic ideal(input logic [2:0] s);
    return s[0] & ~s[1] & s[2];
  endfunction

  function automatic logic [7:0] ideal_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = ideal(3'(i));
    return m;
  endfunction

  always @(posedge clk) begin
    dly_a <= {dly_a[0], ideal(bus_a.stim)};
    dly_b <= {dly_b[0], ideal(bus_b.stim)};
  end

  assign bus_a.dut_out = delay_mode ? dly_a[1] : tbl[bus_a.stim];
  assign bus_b.dut_out = dly_b[1];

  // Starts a run on bus_a and follows it to done; reports latency and stim-walk deviations.
  task automatic run_once(output int lat, output int walk_bad);
    lat = -1;
    walk_bad = 0;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (bus_a.done === 1'b1) begin
        lat = j;
        break;
      end
      if (bus_a.busy !== 1'b1 || bus_a.stim !== 3'(j / (S_A + 1))) walk_bad++;
      if (chatter) bus_a.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
    checks++; if (bus_a.pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", bus_a.pass); end
    checks++; if (bus_a.stim !== 3'd0) begin failures++; $display("FAIL reset_stim got=%0d exp=0", bus_a.stim); end
    checks++; if (bus_a.err_count !== 4'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus_a.err_count); end
    checks++; if (bus_a.fail_map !== 8'h00) begin failures++; $display("FAIL reset_map got=%h exp=00", bus_a.fail_map); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    int lat, wb;
    tbl = ideal_mask();
    run_once(lat, wb);
    checks++; if (lat != 8 * (S_A + 1)) begin failures++; $display("FAIL ideal_latency got=%0d exp=%0d", lat, 8 * (S_A + 1)); end
    checks++; if (wb != 0) begin failures++; $display("FAIL ideal_stim_walk got=%0d bad cycles exp=0", wb); end
    checks++; if (bus_a.pass !== 1'b1) begin failures++; $display("FAIL ideal_pass got=%b exp=1", bus_a.pass); end
    checks++; if (bus_a.err_count !== 4'd0) begin failures++; $display("FAIL ideal_err got=%0d exp=0", bus_a.err_count); end
    checks++; if (bus_a.fail_map !== 8'h00) begin failures++; $display("FAIL ideal_map got=%h exp=00", bus_a.fail_map); end
    repeat (3) @(negedge clk);
    checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.stim !== 3'd0)
      begin failures++; $display("FAIL ideal_hold got done=%b busy=%b stim=%0d exp 1 0 0", bus_a.done, bus_a.busy, bus_a.stim); end
  endtask

  task automatic test_stuck();
    int lat, wb;
    tbl = 8'h00;
    run_once(lat, wb);
    checks++; if (bus_a.err_count !== 4'd1 || bus_a.fail_map !== 8'h20 || bus_a.pass !== 1'b0)
      begin failures++; $display("FAIL stuck0 got err=%0d map=%h pass=%b exp 1 20 0", bus_a.err_count, bus_a.fail_map, bus_a.pass); end
    tbl = 8'hFF;
    run_once(lat, wb);
    checks++; if (bus_a.err_count !== 4'd7 || bus_a.fail_map !== 8'hDF || bus_a.pass !== 1'b0)
      begin failures++; $display("FAIL stuck1 got err=%0d map=%h pass=%b exp 7 df 0", bus_a.err_count, bus_a.fail_map, bus_a.pass); end
  endtask

  task automatic test_random();
    int lat, wb, exp_err;
    logic [7:0] exp_map;
    for (int it = 0; it < 6; it++) begin
      tbl = 8'($urandom);
      exp_map = tbl ^ ideal_mask();
      exp_err = $countones(exp_map);
      run_once(lat, wb);
      checks++; if (bus_a.fail_map !== exp_map) begin failures++; $display("FAIL rand_map it=%0d got=%h exp=%h", it, bus_a.fail_map, exp_map); end
      checks++; if (bus_a.err_count !== 4'(exp_err)) begin failures++; $display("FAIL rand_err it=%0d got=%0d exp=%0d", it, bus_a.err_count, exp_err); end
      checks++; if (bus_a.pass !== (exp_err == 0)) begin failures++; $display("FAIL rand_pass it=%0d got=%b exp=%b", it, bus_a.pass, exp_err == 0); end
    end
  endtask

  task automatic test_delay();
    int lat, wb;
    delay_mode = 1'b1;
    run_once(lat, wb);
    checks++; if (bus_a.pass !== 1'b1 || bus_a.err_count !== 4'd0)
      begin failures++; $display("FAIL delay_settle2 got pass=%b err=%0d exp 1 0", bus_a.pass, bus_a.err_count); end
    @(negedge clk); bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    lat = -1;
    for (int j = 0; j < 60; j++) begin
      if (bus_b.done === 1'b1) begin lat = j; break; end
      @(negedge clk);
    end
    checks++; if (lat != 8 * (S_B + 1)) begin failures++; $display("FAIL delay_settle1_latency got=%0d exp=%0d", lat, 8 * (S_B + 1)); end
    checks++; if (bus_b.pass !== 1'b0 || bus_b.err_count == 4'd0)
      begin failures++; $display("FAIL delay_settle1 got pass=%b err=%0d exp pass=0 err>0", bus_b.pass, bus_b.err_count); end
    delay_mode = 1'b0;
  endtask

  task automatic test_busy_start();
    int lat, wb, exp_err;
    logic [7:0] exp_map;
    chatter = 1'b1;
    tbl = 8'($urandom);
    exp_map = tbl ^ ideal_mask();
    exp_err = $countones(exp_map);
    run_once(lat, wb);
    chatter = 1'b0;
    checks++; if (lat != 8 * (S_A + 1)) begin failures++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, 8 * (S_A + 1)); end
    checks++; if (wb != 0) begin failures++; $display("FAIL busy_start_walk got=%0d bad cycles exp=0", wb); end
    checks++; if (bus_a.fail_map !== exp_map || bus_a.err_count !== 4'(exp_err))
      begin failures++; $display("FAIL busy_start_result got map=%h err=%0d exp %h %0d", bus_a.fail_map, bus_a.err_count, exp_map, exp_err); end
  endtask

  task automatic test_reset_midrun();
    int lat, wb;
    tbl = 8'hFF;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    for (int j = 0; j < 60 && bus_a.stim !== 3'd4; j++) @(negedge clk);
    checks++; if (bus_a.stim !== 3'd4) begin failures++; $display("FAIL midrun_reach_idx4 got=%0d exp=4", bus_a.stim); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus_a.busy !== 1'b0 || bus_a.stim !== 3'd0 || bus_a.done !== 1'b0 || bus_a.pass !== 1'b0 ||
                  bus_a.err_count !== 4'd0 || bus_a.fail_map !== 8'h00)
      begin failures++; $display("FAIL midrun_async_reset got busy=%b stim=%0d done=%b pass=%b err=%0d map=%h exp all 0",
                                 bus_a.busy, bus_a.stim, bus_a.done, bus_a.pass, bus_a.err_count, bus_a.fail_map); end
    @(negedge clk); reset = 1'b0;
    tbl = ideal_mask();
    run_once(lat, wb);
    checks++; if (lat != 8 * (S_A + 1) || wb != 0 || bus_a.pass !== 1'b1)
      begin failures++; $display("FAIL midrun_clean_rerun got lat=%0d walk=%0d pass=%b exp %0d 0 1", lat, wb, bus_a.pass, 8 * (S_A + 1)); end
  endtask

`ifdef GATE_SEQ_LOOP_EN
  task automatic test_loop();
    int k, prev, lat, exp_err;
    tbl = ideal_mask() ^ 8'h08;
    bus_a.loop = 1'b1;
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    k = 0;
    prev = 0;
    for (int j = 0; j < 30 * 17 && k < 17; j++) begin
      if (bus_a.done === 1'b1) begin
        k++;
        exp_err = (k > 15) ? 15 : k;
        checks++; if (j - prev != 8 * (S_A + 1)) begin failures++; $display("FAIL loop_period pulse=%0d got=%0d exp=%0d", k, j - prev, 8 * (S_A + 1)); end
        checks++; if (bus_a.err_count !== 4'(exp_err) || bus_a.fail_map !== 8'h08)
          begin failures++; $display("FAIL loop_result pulse=%0d got err=%0d map=%h exp %0d 08", k, bus_a.err_count, bus_a.fail_map, exp_err); end
        prev = j;
      end
      @(negedge clk);
    end
    checks++; if (k != 17) begin failures++; $display("FAIL loop_pulse_count got=%0d exp=17", k); end
    bus_a.loop = 1'b0;
    lat = -1;
    for (int j = 0; j < 40; j++) begin
      if (bus_a.done === 1'b1) begin lat = j; break; end
      @(negedge clk);
    end
    checks++; if (lat < 0) begin failures++; $display("FAIL loop_stop_timeout got=%0d exp>=0", lat); end
    repeat (3) @(negedge clk);
    checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.err_count !== 4'd15 || bus_a.fail_map !== 8'h08 || bus_a.pass !== 1'b0)
      begin failures++; $display("FAIL loop_stop_hold got done=%b busy=%b err=%0d map=%h pass=%b exp 1 0 15 08 0",
                                 bus_a.done, bus_a.busy, bus_a.err_count, bus_a.fail_map, bus_a.pass); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
`ifdef GATE_SEQ_LOOP_EN
    bus_a.loop = 1'b0;
    bus_b.loop = 1'b0;
`endif
    test_reset();
    test_ideal();
    test_stuck();
    test_random();
    test_delay();
    test_busy_start();
    test_reset_midrun();
`ifdef GATE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
